// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared state type and default geometry for the
// multi-port register file.
package regfile_mp_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // CLEAR: zeroing sweep in progress; RUN: normal operation
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_mp_clear.sv
// regfile_mp_clear: post-reset clear sequencer. Walks clr_ptr from 1 up to
// the last register, requesting one zero-write per cycle, then raises ready.
// Register 0 is never swept because it always reads as zero.
module regfile_mp_clear
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, ptr_nxt;

  // State and sweep pointer; reset restarts the sweep from any state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= PTR_FIRST;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  end

  // Next state: leave CLEAR on the cycle the last register is cleared,
  // so the pointer never wraps
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr_ptr == PTR_LAST) state_nxt = RUN;
        else                     ptr_nxt   = clr_ptr + PTR_FIRST;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready    = (state == RUN);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD asynchronous read ports, two synchronous write ports
// (port 1 wins on a same-address collision), a debug read port, and a
// post-reset clear sweep. Reads return zero until the sweep completes.
// Optional same-cycle write-to-read forwarding: define REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  wen0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  wen1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  output logic                  wconflict,
  input  logic [ADDR_W-1:0]     rf_addr,
  output logic [DATA_W-1:0]     rf_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_mp_clear #(.ADDR_W(ADDR_W)) u_clear (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write is accepted only in RUN, outside reset, and never to r0
  logic acc0, acc1, same_addr, commit0;
  assign acc0      = ready && !reset && wen0 && (waddr0 != '0);
  assign acc1      = ready && !reset && wen1 && (waddr1 != '0);
  assign same_addr = acc0 && acc1 && (waddr0 == waddr1);
  assign commit0   = acc0 && !same_addr;

  // Storage: sweep zero-writes during CLEAR, port writes during RUN.
  // The two sources are mutually exclusive because acceptance needs ready.
  always_ff @(posedge clk) begin
    if (clr_we)  mem[clr_addr] <= '0;
    if (commit0) mem[waddr0]   <= wdata0;
    if (acc1)    mem[waddr1]   <= wdata1;
  end

  // Collision flag, visible for the single cycle after the dual write
  always_ff @(posedge clk) begin
    if (reset) wconflict <= 1'b0;
    else       wconflict <= same_addr;
  end

  // Read ports: indices 0..NRD-1 are the datapath ports, index NRD is the
  // debug display port; all share the same masking and forwarding rules
  logic [NRD:0][ADDR_W-1:0] rd_addr;
  logic [NRD:0][DATA_W-1:0] rd_val;

  always_comb begin
    for (int i = 0; i < NRD; i++) rd_addr[i] = raddr[i*ADDR_W +: ADDR_W];
    rd_addr[NRD] = rf_addr;
  end

  for (genvar gi = 0; gi <= NRD; gi++) begin : g_rd
    logic [DATA_W-1:0] val;

    // Zero for r0 or while not ready; newest write data when forwarding
    always_comb begin
      val = '0;
      if (ready && rd_addr[gi] != '0) begin
        val = mem[rd_addr[gi]];
`ifdef REGFILE_MP_BYPASS_EN
        if (acc0 && waddr0 == rd_addr[gi]) val = wdata0;
        if (acc1 && waddr1 == rd_addr[gi]) val = wdata1;
`endif
      end
    end

    assign rd_val[gi] = val;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) rdata[i*DATA_W +: DATA_W] = rd_val[i];
  end
  assign rf_data = rd_val[NRD];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp against a register-array
// model, with literal spot checks. Honours REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 0;
  logic              reset = 1;
  logic              ready;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NR*DW-1:0]  rdata;
  logic              wen0 = 0, wen1 = 0;
  logic [AW-1:0]     waddr0 = '0, waddr1 = '0;
  logic [DW-1:0]     wdata0 = '0, wdata1 = '0;
  logic              wconflict;
  logic [AW-1:0]     rf_addr = '0;
  logic [DW-1:0]     rf_data;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .raddr(raddr), .rdata(rdata),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .wconflict(wconflict), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_run  = 0;
  bit            m_conf = 0;
  int            m_left = 0;

  always @(posedge clk) begin
    m_conf = 0;
    if (!reset && m_run) begin
      if (wen0 && wen1 && waddr0 == waddr1 && waddr0 != 0) m_conf = 1;
      if (wen0 && waddr0 != 0) m_reg[waddr0] = wdata0;
      if (wen1 && waddr1 != 0) m_reg[waddr1] = wdata1;
    end
    if (reset) begin
      m_run  = 0;
      m_left = DEPTH - 1;
    end else if (!m_run) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_run = 1;
        for (int k = 0; k < DEPTH; k++) m_reg[k] = '0;
      end
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!m_run || a == 0) return '0;
    v = m_reg[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (!reset && wen0 && waddr0 == a) v = wdata0;
    if (!reset && wen1 && waddr1 == a) v = wdata1;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every cycle once the model is defined
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'd0, ready}, {31'd0, m_run});
      check("wconflict", {31'd0, wconflict}, {31'd0, m_conf});
      for (int i = 0; i < NR; i++)
        check($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_read(raddr[i*AW +: AW]));
      check("rf_data", rf_data, exp_read(rf_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wen0 = 0; wen1 = 0;
  endtask

  task automatic set_raddr(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  // Count edges after the reset edge until ready rises (bounded)
  task automatic count_sweep(input string name);
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check(name, n, 31);
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    logic [DW-1:0] old9;
    tick();
    chk_en = 1;
    // reset values while reset held
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_wconflict", {31'd0, wconflict}, 0);
    check("rst_rdata", rdata[DW-1:0], 0);
    check("rst_rf_data", rf_data, 0);
    reset = 0;
    count_sweep("sweep_len");

    // fill with DEADBEEF, then reset and verify the sweep zeroes everything
    for (int a = 1; a < DEPTH; a++) begin
      wen0 = 1; waddr0 = AW'(a); wdata0 = 32'hDEADBEEF;
      tick();
    end
    idle();
    rf_addr = 9; #1;
    check("fill_r9", rf_data, 32'hDEADBEEF);
    tick();
    pulse_reset();
    count_sweep("sweep_len2");
    for (int a = 0; a < DEPTH; a++) begin
      rf_addr = AW'(a); #1;
      check($sformatf("clr_r%0d", a), rf_data, 0);
    end

    // basic write/read on every port
    wen0 = 1; waddr0 = 5; wdata0 = 32'h12345678;
    set_raddr(0, 5); set_raddr(1, 5);
    tick(); idle(); #1;
    check("r5_p0", rdata[0 +: DW], 32'h12345678);
    check("r5_p1", rdata[DW +: DW], 32'h12345678);

    // r0 dual write: no effect, no conflict
    wen0 = 1; waddr0 = 0; wdata0 = '1;
    wen1 = 1; waddr1 = 0; wdata1 = '1;
    set_raddr(0, 0);
    tick(); idle(); #1;
    check("r0_read", rdata[0 +: DW], 0);
    check("r0_noconf", {31'd0, wconflict}, 0);

    // same-address dual write: port 1 wins, one-cycle pulse
    wen0 = 1; waddr0 = 7; wdata0 = 32'hAAAA0000;
    wen1 = 1; waddr1 = 7; wdata1 = 32'h0000BBBB;
    set_raddr(0, 7);
    tick(); idle(); #1;
    check("conf_pulse", {31'd0, wconflict}, 1);
    check("r7", rdata[0 +: DW], 32'h0000BBBB);
    tick();
    check("conf_drop", {31'd0, wconflict}, 0);

    // different-address dual write
    wen0 = 1; waddr0 = 3; wdata0 = 32'h33;
    wen1 = 1; waddr1 = 4; wdata1 = 32'h44;
    set_raddr(0, 3); set_raddr(1, 4);
    tick(); idle(); #1;
    check("dual_noconf", {31'd0, wconflict}, 0);
    check("r3", rdata[0 +: DW], 32'h33);
    check("r4", rdata[DW +: DW], 32'h44);

    // same-cycle read of a write: forwarded only with bypass
    wen0 = 1; waddr0 = 9; wdata0 = 32'h11;
    tick(); idle();
    old9 = 32'h11;
    wen0 = 1; waddr0 = 9; wdata0 = 32'h55;
    set_raddr(0, 9); rf_addr = 9; #1;
`ifdef REGFILE_MP_BYPASS_EN
    check("byp_rdata", rdata[0 +: DW], 32'h55);
    check("byp_rf", rf_data, 32'h55);
`else
    check("byp_rdata", rdata[0 +: DW], old9);
    check("byp_rf", rf_data, old9);
`endif
    tick(); idle(); #1;
    check("r9_after", rdata[0 +: DW], 32'h55);

    // mixed traffic, checked by the compare process every cycle
    for (int i = 0; i < 40; i++) begin
      wen0 = (i % 3) != 0;  waddr0 = AW'((i * 7) % DEPTH);  wdata0 = 32'h1000 + i;
      wen1 = (i % 4) == 1;  waddr1 = AW'((i * 5) % DEPTH);  wdata1 = 32'hA000 + i;
      if (i % 8 == 3) waddr1 = waddr0;
      set_raddr(0, AW'((i * 7) % DEPTH));
      set_raddr(1, AW'((i * 11 + 3) % DEPTH));
      rf_addr = AW'((i * 3) % DEPTH);
      tick();
    end
    idle();
    tick();

    // write accompanied by reset is discarded; reset mid-sweep restarts it
    wen0 = 1; waddr0 = 12; wdata0 = 32'h99;
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) tick();
    wen0 = 1; waddr0 = 12; wdata0 = 32'h99;
    tick(); idle();
    pulse_reset();
    count_sweep("midsweep_len");
    rf_addr = 12; #1;
    check("r12_discard", rf_data, 0);
    tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the multi-cycle CPU datapath. It generalises the two-read/one-write register file to NRD asynchronous read ports and two synchronous write ports, with a defined write-conflict priority and a debug read port for the register display. A clear state machine zeroes every register after reset and holds `ready` low until the sweep is done. Same-cycle write-to-read forwarding is optional.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^ADDR_W; register 0 reads as zero
- `NRD`, 2, number of read ports (1..4)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `ready`  out  1  high when the clear sweep is done and writes are accepted
- `raddr`  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- `rdata`  out  NRD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- `wen0`, `waddr0`, `wdata0`  in  1/ADDR_W/DATA_W  write port 0
- `wen1`, `waddr1`, `wdata1`  in  1/ADDR_W/DATA_W  write port 1, higher priority
- `wconflict`  out  1  one-cycle pulse for an accepted same-address dual write
- `rf_addr`  in  ADDR_W  debug display address
- `rf_data`  out  DATA_W  debug display data

## Operation
- FSM states:
  - CLEAR: `clr_ptr` runs 1 .. 2^ADDR_W-1. One register is written with 0 per cycle.
  - RUN: normal operation.
- State transitions:
  - `reset`=1 at a rising edge: state becomes CLEAR, `clr_ptr` becomes 1. This applies from any state, including mid-sweep, which restarts the sweep.
  - CLEAR with `clr_ptr`=2^ADDR_W-1: that register is cleared, then state becomes RUN.
- Writes are accepted only in RUN, when `reset`=0 and `wenX`=1. A write to address 0 is discarded.
- Both write ports target the same nonzero address while both are enabled and accepted:
  - `wdata1` is stored.
  - `wconflict`=1 on the following cycle only.
- Writes to different addresses both commit on the same edge.
- Reads are combinational:
  - Address 0 returns 0.
  - Any port returns 0 while `ready`=0. This includes `rf_data`.
- No arithmetic is performed. `clr_ptr` is ADDR_W bits wide and does not wrap; the FSM leaves CLEAR before it would wrap.

## Timing
- Reset values: `ready`=0, `wconflict`=0, `rdata`=0, `rf_data`=0.
- Clear sweep: `ready` rises 2^ADDR_W-1 cycles after the reset edge. That is 31 cycles at ADDR_W=5.
- Write latency: data written at edge N is visible on read ports after edge N, without bypass.
- With bypass, a read in the same cycle as the write returns the write data.
- `wconflict` is registered. It is high for exactly one cycle and is cleared by `reset`.
- `reset` asserted in the same cycle as a write: the write is discarded.

## Configuration
- Macro: `REGFILE_MP_BYPASS_EN`.
- Defined:
  - A read port whose nonzero address matches an enabled write port in RUN returns that port's `wdata` combinationally.
  - If both write ports match, `wdata1` is returned.
  - `rf_data` is also bypassed.
- Undefined: read ports always return stored contents.

## Structure
- Package `regfile_mp_pkg` holds:
  - the state typedef `rf_state_t` {CLEAR, RUN};
  - the default constants `RF_DATA_W` and `RF_ADDR_W`.
- Sub-module `regfile_mp_clear` holds the CLEAR/RUN FSM and `clr_ptr`. It outputs `ready`, `clr_we` and `clr_addr`.
- The top module holds the storage array, the write priority logic, the read mux, the bypass, and `wconflict`.

## Test plan
- Reset sweep:
  - Pulse `reset` for 1 cycle, then count cycles. `ready` must rise after exactly 31 cycles (ADDR_W=5).
  - After the sweep, all 32 `rf_data` reads return 0, even where registers held 0xDEADBEEF before reset.
- Basic write/read: write `wdata0`=0x12345678 to r5, then read r5 on every read port. All ports return 0x12345678 from the next cycle.
- Register 0: write 0xFFFFFFFF to r0 on both ports. r0 still reads 0 and `wconflict` stays 0.
- Dual-write conflict:
  - Port 0 writes 0xAAAA0000 and port 1 writes 0x0000BBBB, both to r7. r7 = 0x0000BBBB and `wconflict` pulses for 1 cycle.
  - Dual writes to r3 and r4 land in both registers with no `wconflict` pulse.
- Reset mid-sweep: assert `reset` 10 cycles into the sweep. `ready` rises 31 cycles after the second reset. A write attempted during CLEAR is discarded and reads 0.
- Bypass (`REGFILE_MP_BYPASS_EN`): write 0x55 to r9 and read r9 in the same cycle. The result is 0x55 with the macro defined, and the old value without it.
